dostring_frame_rx: RTL and testbench



---
 rtl/dostring_frame_rx.sv | 188 ++++++++++++++++++
 tb/tb_dostring_frame_rx.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dostring_frame_rx.sv
// dostring_frame_rx
// Receive side of the wand LED SPI link. Oversamples sck/mosi with
// dostring_clk, bit-aligns on a 32-bit all-zero start word, and decodes the
// following LED words into per-LED colour records until an all-ones end word.
// Framing, overflow and timeout faults raise a one-cycle frame_error pulse.
//
// Optional feature: define DOSTRING_FRAME_RX_LEN_CHECK_EN to have an end word
// whose LED count differs from STRING_SIZE also pulse frame_error alongside
// end_seen.
`timescale 1ns/1ps

module dostring_frame_rx #(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int MAX_LEDS       = 255,
   parameter int STRING_SIZE    = 47
) (
   input  logic       dostring_clk,
   input  logic       dostring_reset,
   input  logic       sck_in,
   input  logic       mosi_in,
   output logic       led_valid,
   output logic [7:0] led_index,
   output logic [4:0] led_brightness,
   output logic [7:0] led_blue,
   output logic [7:0] led_green,
   output logic [7:0] led_red,
   output logic       start_seen,
   output logic       end_seen,
   output logic [7:0] led_count,
   output logic       frame_error
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef DOSTRING_FRAME_RX_LEN_CHECK_EN
   localparam bit LEN_CHECK = 1'b1;
`else
   localparam bit LEN_CHECK = 1'b0;
`endif

   typedef enum logic {
      HUNT,
      INSIDE
   } state_t;

   logic          r_sckS1;
   logic          r_sckS2;
   logic          r_sckS3;
   logic          r_mosiS1;
   logic          r_mosiS2;
   state_t        r_state;
   logic [30:0]   r_shift;
   logic [4:0]    r_bitCnt;
   logic [5:0]    r_zeroRun;
   logic [TW-1:0] r_toCnt;
   logic [8:0]    r_ledCnt;

   logic          w_rise;
   logic          w_bit;
   logic [31:0]   w_word;

   // mosi goes through the same two-flop depth as sck so that the data bit
   // sampled on a detected rise is the one that was present at the edge
   assign w_rise = r_sckS2 & ~r_sckS3;
   assign w_bit  = r_mosiS2;
   assign w_word = {r_shift, w_bit};

   // Bring the asynchronous link signals into the dostring_clk domain
   always_ff @(posedge dostring_clk or posedge dostring_reset) begin
      if (dostring_reset) begin
         r_sckS1  <= 1'b0;
         r_sckS2  <= 1'b0;
         r_sckS3  <= 1'b0;
         r_mosiS1 <= 1'b0;
         r_mosiS2 <= 1'b0;
      end else begin
         r_sckS1  <= sck_in;
         r_sckS2  <= r_sckS1;
         r_sckS3  <= r_sckS2;
         r_mosiS1 <= mosi_in;
         r_mosiS2 <= r_mosiS1;
      end
   end

   // Framing state machine: hunts for a start word, then assembles and
   // decodes 32-bit words, with every output registered
   always_ff @(posedge dostring_clk or posedge dostring_reset) begin
      if (dostring_reset) begin
         r_state        <= HUNT;
         r_shift        <= '0;
         r_bitCnt       <= '0;
         r_zeroRun      <= '0;
         r_toCnt        <= '0;
         r_ledCnt       <= '0;
         led_valid      <= 1'b0;
         led_index      <= '0;
         led_brightness <= '0;
         led_blue       <= '0;
         led_green      <= '0;
         led_red        <= '0;
         start_seen     <= 1'b0;
         end_seen       <= 1'b0;
         led_count      <= '0;
         frame_error    <= 1'b0;
      end else begin
         led_valid   <= 1'b0;
         start_seen  <= 1'b0;
         end_seen    <= 1'b0;
         frame_error <= 1'b0;

         case (r_state)
            HUNT: begin
               r_toCnt <= '0;
               if (w_rise) begin
                  if (!w_bit) begin
                     if (r_zeroRun == 6'd31) begin
                        start_seen <= 1'b1;
                        led_index  <= '0;
                        r_ledCnt   <= '0;
                        r_bitCnt   <= '0;
                        r_zeroRun  <= '0;
                        r_state    <= INSIDE;
                     end else begin
                        r_zeroRun <= r_zeroRun + 6'd1;
                     end
                  end else begin
                     r_zeroRun <= '0;
                  end
               end
            end

            INSIDE: begin
               if (w_rise) begin
                  r_toCnt  <= '0;
                  r_shift  <= w_word[30:0];
                  r_bitCnt <= r_bitCnt + 5'd1;
                  if (r_bitCnt == 5'd31) begin
                     if (w_word == 32'h0000_0000) begin
                        start_seen <= 1'b1;
                        led_index  <= '0;
                        r_ledCnt   <= '0;
                     end else if (w_word == 32'hFFFF_FFFF) begin
                        end_seen  <= 1'b1;
                        led_count <= r_ledCnt[7:0];
                        r_state   <= HUNT;
                        if (LEN_CHECK && (r_ledCnt != 9'(STRING_SIZE))) begin
                           frame_error <= 1'b1;
                        end
                     end else if (w_word[31:29] == 3'b111) begin
                        if (r_ledCnt >= 9'(MAX_LEDS)) begin
                           frame_error <= 1'b1;
                           r_state     <= HUNT;
                        end else begin
                           led_valid      <= 1'b1;
                           led_index      <= r_ledCnt[7:0];
                           led_brightness <= w_word[28:24];
                           led_blue       <= w_word[23:16];
                           led_green      <= w_word[15:8];
                           led_red        <= w_word[7:0];
                           r_ledCnt       <= r_ledCnt + 9'd1;
                        end
                     end else begin
                        frame_error <= 1'b1;
                        r_state     <= HUNT;
                     end
                  end
               end else if (r_bitCnt != 5'd0) begin
                  if (r_toCnt == TW'(TIMEOUT_CYCLES - 1)) begin
                     frame_error <= 1'b1;
                     r_bitCnt    <= '0;
                     r_toCnt     <= '0;
                     r_state     <= HUNT;
                  end else begin
                     r_toCnt <= r_toCnt + TW'(1);
                  end
               end else begin
                  r_toCnt <= '0;
               end
            end

            default: begin
               r_state <= HUNT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dostring_frame_rx.sv
// tb_dostring_frame_rx
// Drives bit-serial SPI words into dostring_frame_rx and checks every output
// pulse against a word-level reference model through an expected-event queue.
`timescale 1ns/1ps

module tb_dostring_frame_rx;

   localparam int TIMEOUT = 4096;
   localparam int MAXL    = 255;
   localparam int SSIZE   = 47;
   localparam int HALF    = 2;

   logic       dostring_clk = 1'b0;
   logic       dostring_reset;
   logic       sck_in;
   logic       mosi_in;
   logic       led_valid;
   logic [7:0] led_index;
   logic [4:0] led_brightness;
   logic [7:0] led_blue;
   logic [7:0] led_green;
   logic [7:0] led_red;
   logic       start_seen;
   logic       end_seen;
   logic [7:0] led_count;
   logic       frame_error;

   // kind bits are {led_valid, start_seen, end_seen, frame_error}
   typedef struct {
      logic [3:0]  kind;
      logic [7:0]  idx;
      logic [31:0] word;
      logic [7:0]  cnt;
   } exp_t;

   exp_t        expQ[$];
   int          compared   = 0;
   int          mismatched = 0;

   bit          mHunt    = 1'b1;
   int          mZeroRun = 0;
   int          mBits    = 0;
   logic [31:0] mWord    = '0;
   int          mCnt     = 0;

   // 100 MHz system clock
   always #5 dostring_clk = ~dostring_clk;

   dostring_frame_rx #(
      .TIMEOUT_CYCLES(TIMEOUT),
      .MAX_LEDS(MAXL),
      .STRING_SIZE(SSIZE)
   ) dut (
      .dostring_clk(dostring_clk),
      .dostring_reset(dostring_reset),
      .sck_in(sck_in),
      .mosi_in(mosi_in),
      .led_valid(led_valid),
      .led_index(led_index),
      .led_brightness(led_brightness),
      .led_blue(led_blue),
      .led_green(led_green),
      .led_red(led_red),
      .start_seen(start_seen),
      .end_seen(end_seen),
      .led_count(led_count),
      .frame_error(frame_error)
   );

   function automatic void pushEv(logic [3:0] kind, int idx, logic [31:0] word, int cnt);
      exp_t e;
      e.kind = kind;
      e.idx  = 8'(idx);
      e.word = word;
      e.cnt  = 8'(cnt);
      expQ.push_back(e);
   endfunction

   // Word-level meaning of a completed 32-bit word inside a string
   function automatic void modelWord(logic [31:0] w);
      if (w == 32'h0) begin
         pushEv(4'b0100, 0, w, 0);
         mCnt = 0;
      end else if (w == 32'hFFFF_FFFF) begin
`ifdef DOSTRING_FRAME_RX_LEN_CHECK_EN
         pushEv((mCnt != SSIZE) ? 4'b0011 : 4'b0010, 0, w, mCnt);
`else
         pushEv(4'b0010, 0, w, mCnt);
`endif
         mHunt = 1'b1;
      end else if (w[31:29] == 3'b111) begin
         if (mCnt >= MAXL) begin
            pushEv(4'b0001, 0, w, 0);
            mHunt = 1'b1;
         end else begin
            pushEv(4'b1000, mCnt, w, 0);
            mCnt++;
         end
      end else begin
         pushEv(4'b0001, 0, w, 0);
         mHunt = 1'b1;
      end
   endfunction

   // Bit-level view: a run of 32 zeros while hunting opens a string
   function automatic void modelBit(logic b);
      if (mHunt) begin
         mZeroRun = b ? 0 : mZeroRun + 1;
         if (mZeroRun == 32) begin
            pushEv(4'b0100, 0, 32'h0, 0);
            mHunt    = 1'b0;
            mCnt     = 0;
            mBits    = 0;
            mZeroRun = 0;
         end
      end else begin
         mWord = {mWord[30:0], b};
         mBits++;
         if (mBits == 32) begin
            mBits = 0;
            modelWord(mWord);
            if (mHunt) mZeroRun = 0;
         end
      end
   endfunction

   // A long enough silence in the middle of a word abandons the string
   function automatic void modelIdle(int cycles);
      if (!mHunt && mBits != 0 && cycles >= TIMEOUT) begin
         pushEv(4'b0001, 0, 32'h0, 0);
         mHunt    = 1'b1;
         mBits    = 0;
         mZeroRun = 0;
      end
   endfunction

   function automatic void modelReset();
      mHunt    = 1'b1;
      mZeroRun = 0;
      mBits    = 0;
      mCnt     = 0;
   endfunction

   function automatic logic [31:0] randLed();
      logic [31:0] w;
      w = {3'b111, 29'($urandom)};
      if (&w) w[0] = 1'b0;
      return w;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Sends one bit: data set while sck is low, then a rising edge
   task automatic sendBit(input logic b);
      @(negedge dostring_clk) mosi_in = b;
      repeat (HALF) @(negedge dostring_clk);
      sck_in = 1'b1;
      modelBit(b);
      repeat (HALF) @(negedge dostring_clk);
      sck_in = 1'b0;
   endtask

   // Sends the top nbits of a word, MSB first
   task automatic applyStimulus(input logic [31:0] w, input int nbits);
      for (int i = 31; i > 31 - nbits; i--) sendBit(w[i]);
   endtask

   task automatic idle(input int n);
      modelIdle(n);
      repeat (n) @(negedge dostring_clk);
   endtask

   task automatic sendString(input int nLeds, input bit fixedLed);
      applyStimulus(32'h0, 32);
      for (int i = 0; i < nLeds; i++)
         applyStimulus(fixedLed ? {3'b111, 5'h1F, 8'd200, 8'd0, 8'd150} : randLed(), 32);
      applyStimulus(32'hFFFF_FFFF, 32);
   endtask

   // Monitor: every output pulse is popped against the next expected event
   always @(negedge dostring_clk) begin
      if (!dostring_reset && (led_valid | start_seen | end_seen | frame_error)) begin
         logic [3:0] act;
         act = {led_valid, start_seen, end_seen, frame_error};
         compared++;
         if (expQ.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL unexpectedEvent: got kind=%b idx=%0d, expected no event", act, led_index);
         end else begin
            exp_t e;
            bit   ok;
            e  = expQ.pop_front();
            ok = (act == e.kind);
            if (e.kind[3])
               ok = ok && ({led_index, led_brightness, led_blue, led_green, led_red} ==
                           {e.idx, e.word[28:24], e.word[23:16], e.word[15:8], e.word[7:0]});
            if (e.kind[1])
               ok = ok && (led_count == e.cnt);
            if (!ok) begin
               mismatched++;
               $display("[TB] FAIL event: got kind=%b idx=%0d br=%0d b=%0d g=%0d r=%0d cnt=%0d, expected kind=%b idx=%0d br=%0d b=%0d g=%0d r=%0d cnt=%0d",
                        act, led_index, led_brightness, led_blue, led_green, led_red, led_count,
                        e.kind, e.idx, e.word[28:24], e.word[23:16], e.word[15:8], e.word[7:0], e.cnt);
            end
         end
      end
   end

   // Directed and randomized scenarios in sequence
   initial begin
      dostring_reset = 1'b1;
      sck_in         = 1'b0;
      mosi_in        = 1'b0;
      repeat (4) @(negedge dostring_clk);
      checkOutput("rstPulses", 64'({led_valid, start_seen, end_seen, frame_error}), 64'h0);
      checkOutput("rstIndex", 64'(led_index), 64'h0);
      checkOutput("rstFields", 64'({led_brightness, led_blue, led_green, led_red}), 64'h0);
      checkOutput("rstCount", 64'(led_count), 64'h0);
      dostring_reset = 1'b0;
      idle(5);

      $display("[TB] full string of %0d fixed LEDs", SSIZE);
      sendString(SSIZE, 1'b1);
      idle(10);
      checkOutput("countFull", 64'(led_count), 64'(SSIZE));

      $display("[TB] short random string");
      sendString(1 + int'($urandom_range(0, 9)), 1'b0);
      idle(10);

      $display("[TB] garbage bits then realign");
      for (int i = 0; i < 5; i++) sendBit(1'($urandom));
      applyStimulus(32'h0, 32);
      applyStimulus(randLed(), 32);
      applyStimulus(32'hFFFF_FFFF, 32);
      idle(10);

      $display("[TB] bad word then recovery");
      applyStimulus(32'h0, 32);
      applyStimulus(32'h5A00_0000, 32);
      sendString(1, 1'b0);
      idle(10);

      $display("[TB] mid-word timeout then recovery");
      applyStimulus(32'h0, 32);
      applyStimulus(randLed(), 10);
      idle(TIMEOUT + 1);
      sendString(2, 1'b0);
      idle(10);

      $display("[TB] string one LED short");
      sendString(SSIZE - 1, 1'b0);
      idle(10);
      checkOutput("countShort", 64'(led_count), 64'(SSIZE - 1));

      $display("[TB] LED overflow past the maximum");
      sendString(MAXL + 1, 1'b0);
      idle(10);
      checkOutput("countAfterOverflow", 64'(led_count), 64'(SSIZE - 1));

      $display("[TB] reset in the middle of an LED word");
      begin
         logic [31:0] w;
         w = randLed();
         applyStimulus(32'h0, 32);
         applyStimulus(randLed(), 32);
         applyStimulus(w, 20);
         @(negedge dostring_clk) dostring_reset = 1'b1;
         modelReset();
         repeat (2) @(negedge dostring_clk);
         checkOutput("midRstPulses", 64'({led_valid, start_seen, end_seen, frame_error}), 64'h0);
         checkOutput("midRstOutputs", 64'({led_index, led_brightness, led_blue, led_green, led_red, led_count}), 64'h0);
         dostring_reset = 1'b0;
         idle(3);
         for (int i = 11; i >= 0; i--) sendBit(w[i]);
         idle(10);
      end
      sendString(3, 1'b0);
      idle(20);

      checkOutput("queueEmpty", 64'(expQ.size()), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
